// File: rtl/rr_interval_scheduler.sv
// rr_interval_scheduler
// R-R interval sequencer for the ECG filter chain. It sits between the
// R-peak detector and the output/UART stage. After each accepted peak it
// blanks the detector for a refractory window. It measures the
// peak-to-peak interval in clock ticks, hands the interval downstream over
// a valid/ready handshake, and raises a sticky asystole timeout.
// Optional build macro: RR_AVG_EN adds rr_avg (mean of the last four
// intervals) and rr_overrun (sticky lost-interval flag).
module rr_interval_scheduler #(
   parameter int CNT_W       = 24,
   parameter int REFRACT_CYC = 200,
   parameter int RR_LIMIT    = 2000,
   parameter int BEAT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              peak,
   output logic              blank,
   output logic              rr_valid,
   input  logic              rr_ready,
   output logic [CNT_W-1:0]  rr_count,
   output logic              timeout,
   output logic [BEAT_W-1:0] beat_count
`ifdef RR_AVG_EN
   ,
   output logic [CNT_W-1:0]  rr_avg,
   output logic              rr_overrun
`endif
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ARM     = 3'd1;
   localparam logic [2:0] ST_REFRACT = 3'd2;
   localparam logic [2:0] ST_SEARCH  = 3'd3;
   localparam logic [2:0] ST_TIMEOUT = 3'd4;

   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  REFRACT_V = CNT_W'(REFRACT_CYC);
   localparam logic [CNT_W-1:0]  LIMIT_V   = CNT_W'(RR_LIMIT);
   localparam logic [BEAT_W-1:0] BEAT_ONE  = {{(BEAT_W-1){1'b0}}, 1'b1};

   // The refractory window must fit inside the R-R limit, and the limit
   // must be representable by the interval counter.
   generate
      if (!((REFRACT_CYC < RR_LIMIT) && (64'(RR_LIMIT) < (64'd1 << CNT_W)))) begin : g_param_check
         $error("rr_interval_scheduler: require REFRACT_CYC < RR_LIMIT < 2**CNT_W");
      end
   endgenerate

   // Saturating increment: the interval counter never wraps back to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == CNT_MAX) begin
         r = v;
      end else begin
         r = v + CNT_ONE;
      end
      return r;
   endfunction

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              blank_q, blank_d;
   logic              rr_valid_q, rr_valid_d;
   logic [CNT_W-1:0]  rr_count_q, rr_count_d;
   logic              timeout_q, timeout_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              en_q, en_d;
   logic              en_fall_q, en_fall_d;
   logic              emit_s;
   logic              enter_to_s;

   // Sequencing FSM: next state, interval counter, beat counter and the
   // strobes for an emitted interval and for entry into timeout.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      beat_d     = beat_q;
      emit_s     = 1'b0;
      enter_to_s = 1'b0;
      if (!en) begin
         state_d = ST_IDLE;
         cnt_d   = CNT_ZERO;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_ARM;
               cnt_d   = CNT_ZERO;
            end
            ST_ARM: begin
               // The first beat only starts timing; it has no predecessor.
               if (peak) begin
                  state_d = ST_REFRACT;
                  cnt_d   = CNT_ONE;
                  beat_d  = beat_q + BEAT_ONE;
               end else begin
                  state_d = ST_ARM;
               end
            end
            ST_REFRACT: begin
               // Detector output is ignored here; peak has no effect.
               cnt_d = sat_inc(cnt_q);
               if (cnt_q == REFRACT_V) begin
                  state_d = ST_SEARCH;
               end else begin
                  state_d = ST_REFRACT;
               end
            end
            ST_SEARCH: begin
               // The counter holds the cycles elapsed since the previous
               // accepted peak. This includes the current peak cycle.
               if (peak) begin
                  emit_s  = 1'b1;
                  state_d = ST_REFRACT;
                  cnt_d   = CNT_ONE;
                  beat_d  = beat_q + BEAT_ONE;
               end else if (cnt_q >= LIMIT_V) begin
                  state_d    = ST_TIMEOUT;
                  enter_to_s = 1'b1;
               end else begin
                  cnt_d = sat_inc(cnt_q);
               end
            end
            ST_TIMEOUT: begin
               // The next peak restarts timing. The gap that crossed the
               // limit is not reported as an interval.
               if (peak) begin
                  state_d = ST_REFRACT;
                  cnt_d   = CNT_ONE;
                  beat_d  = beat_q + BEAT_ONE;
               end else begin
                  state_d = ST_TIMEOUT;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = CNT_ZERO;
            end
         endcase
      end
   end

   // Output-side next values: blank follows the next state, the interval
   // register obeys the handshake, and timeout is sticky until en falls.
   always_comb begin
      en_d      = en;
      en_fall_d = en_q & ~en;
      blank_d   = (state_d == ST_REFRACT);
      if (emit_s) begin
         // A fresh interval always wins, even over a same-cycle acceptance.
         rr_valid_d = 1'b1;
         rr_count_d = cnt_q;
      end else if (rr_valid_q && rr_ready) begin
         rr_valid_d = 1'b0;
         rr_count_d = rr_count_q;
      end else begin
         rr_valid_d = rr_valid_q;
         rr_count_d = rr_count_q;
      end
      if (en_fall_q) begin
         timeout_d = 1'b0;
      end else if (enter_to_s) begin
         timeout_d = 1'b1;
      end else begin
         timeout_d = timeout_q;
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= CNT_ZERO;
         blank_q    <= 1'b0;
         rr_valid_q <= 1'b0;
         rr_count_q <= CNT_ZERO;
         timeout_q  <= 1'b0;
         beat_q     <= {BEAT_W{1'b0}};
         en_q       <= 1'b0;
         en_fall_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         blank_q    <= blank_d;
         rr_valid_q <= rr_valid_d;
         rr_count_q <= rr_count_d;
         timeout_q  <= timeout_d;
         beat_q     <= beat_d;
         en_q       <= en_d;
         en_fall_q  <= en_fall_d;
      end
   end

   assign blank      = blank_q;
   assign rr_valid   = rr_valid_q;
   assign rr_count   = rr_count_q;
   assign timeout    = timeout_q;
   assign beat_count = beat_q;

`ifdef RR_AVG_EN
   logic [3:0][CNT_W-1:0] hist_q, hist_d;
   logic                  avg_upd_q, avg_upd_d;
   logic [CNT_W-1:0]      rr_avg_q, rr_avg_d;
   logic                  overrun_q, overrun_d;
   logic [CNT_W+1:0]      sum_s;

   // Four-deep interval history. The mean is taken one cycle after each
   // push. A lost (overwritten) interval latches the overrun flag.
   always_comb begin
      sum_s = {2'b00, hist_q[0]} + {2'b00, hist_q[1]}
            + {2'b00, hist_q[2]} + {2'b00, hist_q[3]};
      if (emit_s) begin
         hist_d = {hist_q[2:0], cnt_q};
      end else begin
         hist_d = hist_q;
      end
      avg_upd_d = emit_s;
      if (avg_upd_q) begin
         rr_avg_d = CNT_W'(sum_s >> 2);
      end else begin
         rr_avg_d = rr_avg_q;
      end
      if (emit_s && rr_valid_q && !rr_ready) begin
         overrun_d = 1'b1;
      end else begin
         overrun_d = overrun_q;
      end
   end

   // Averaging and overrun registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist_q    <= '0;
         avg_upd_q <= 1'b0;
         rr_avg_q  <= CNT_ZERO;
         overrun_q <= 1'b0;
      end else begin
         hist_q    <= hist_d;
         avg_upd_q <= avg_upd_d;
         rr_avg_q  <= rr_avg_d;
         overrun_q <= overrun_d;
      end
   end

   assign rr_avg     = rr_avg_q;
   assign rr_overrun = overrun_q;
`endif

endmodule

// File: tb/tb_rr_interval_scheduler.sv
// tb_rr_interval_scheduler
// Segment table of {repeat, inputs, expected outputs}. Each driven cycle
// pushes its expectation into a scoreboard queue, and the expectation is
// popped and compared after the clock edge. Hand-written sequences cover
// the asynchronous mid-SEARCH reset and restart from IDLE.
// The design is configured with REFRACT_CYC=4 and RR_LIMIT=20.
module tb_rr_interval_scheduler;

   localparam int CNT_W  = 24;
   localparam int BEAT_W = 16;

   logic              clk;
   logic              rst;
   logic              en;
   logic              peak;
   logic              blank;
   logic              rr_valid;
   logic              rr_ready;
   logic [CNT_W-1:0]  rr_count;
   logic              timeout;
   logic [BEAT_W-1:0] beat_count;
`ifdef RR_AVG_EN
   logic [CNT_W-1:0]  rr_avg;
   logic              rr_overrun;
`endif

   rr_interval_scheduler #(
      .CNT_W(CNT_W), .REFRACT_CYC(4), .RR_LIMIT(20), .BEAT_W(BEAT_W)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .peak(peak), .blank(blank),
      .rr_valid(rr_valid), .rr_ready(rr_ready), .rr_count(rr_count),
      .timeout(timeout), .beat_count(beat_count)
`ifdef RR_AVG_EN
      , .rr_avg(rr_avg), .rr_overrun(rr_overrun)
`endif
   );

   typedef struct {
      int                n;
      logic              en;
      logic              peak;
      logic              rdy;
      logic              blank;
      logic              valid;
      logic [CNT_W-1:0]  cnt;
      logic              to;
      logic [BEAT_W-1:0] beat;
      logic [CNT_W-1:0]  avg;
      logic              ovr;
   } seg_t;

   seg_t segs[$];
   seg_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   row      = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog row=%0d actual=not-finished expected=finished", row);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s row=%0d actual=%0d expected=%0d", nm, row, act, exp_v);
      end
   endtask

   task automatic add(input int n, input logic e, input logic p, input logic r,
                      input logic b, input logic v, input logic [CNT_W-1:0] c,
                      input logic t, input logic [BEAT_W-1:0] bt,
                      input logic [CNT_W-1:0] a, input logic o);
      seg_t s;
      s.n = n; s.en = e; s.peak = p; s.rdy = r; s.blank = b; s.valid = v;
      s.cnt = c; s.to = t; s.beat = bt; s.avg = a; s.ovr = o;
      segs.push_back(s);
   endtask

   initial begin
      seg_t ex;
      //    n   en    peak  rdy   blank valid count   to    beat    avg     ovr
      add( 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'd0,  1'b0, 16'd0,  24'd0,  1'b0); // ARM
      add( 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'd0,  1'b0, 16'd1,  24'd0,  1'b0); // peak t=0
      add( 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'd0,  1'b0, 16'd1,  24'd0,  1'b0);
      add( 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'd0,  1'b0, 16'd1,  24'd0,  1'b0); // t=2 ignored
      add( 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'd0,  1'b0, 16'd1,  24'd0,  1'b0);
      add( 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'd0,  1'b0, 16'd1,  24'd0,  1'b0); // SEARCH
      add( 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'd10, 1'b0, 16'd2,  24'd0,  1'b0); // t=10
      add( 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'd10, 1'b0, 16'd2,  24'd2,  1'b0);
      add( 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'd10, 1'b0, 16'd2,  24'd2,  1'b0);
      add( 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'd12, 1'b0, 16'd3,  24'd2,  1'b1); // overwrite
      add( 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'd12, 1'b0, 16'd3,  24'd5,  1'b1); // accept
      add( 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'd12, 1'b0, 16'd3,  24'd5,  1'b1);
      add(16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'd12, 1'b0, 16'd3,  24'd5,  1'b1);
      add( 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'd12, 1'b1, 16'd3,  24'd5,  1'b1); // timeout
      add( 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'd12, 1'b1, 16'd4,  24'd5,  1'b1); // peak in TO
      add( 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'd12, 1'b1, 16'd4,  24'd5,  1'b1);
      add( 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'd12, 1'b1, 16'd4,  24'd5,  1'b1); // en low
      add( 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'd12, 1'b0, 16'd4,  24'd5,  1'b1); // TO cleared
      add( 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'd12, 1'b0, 16'd4,  24'd5,  1'b1);
      add( 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'd12, 1'b0, 16'd5,  24'd5,  1'b1); // first peak
      add( 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'd12, 1'b0, 16'd5,  24'd5,  1'b1);
      add( 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'd12, 1'b0, 16'd5,  24'd5,  1'b1);
      add( 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'd8,  1'b0, 16'd6,  24'd5,  1'b1); // 8
      add( 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'd8,  1'b0, 16'd6,  24'd7,  1'b1);
      add( 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'd8,  1'b0, 16'd6,  24'd7,  1'b1);
      add( 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 24'd12, 1'b0, 16'd7,  24'd7,  1'b1); // 12 + accept
      add( 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'd12, 1'b0, 16'd7,  24'd10, 1'b1);
      add( 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'd12, 1'b0, 16'd7,  24'd10, 1'b1);
      add( 6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'd12, 1'b0, 16'd7,  24'd10, 1'b1);
      add( 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 24'd10, 1'b0, 16'd8,  24'd10, 1'b1); // 10
      add( 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'd10, 1'b0, 16'd8,  24'd10, 1'b1);
      add( 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'd10, 1'b0, 16'd8,  24'd10, 1'b1);
      add(10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'd10, 1'b0, 16'd8,  24'd10, 1'b1);
      add( 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'd14, 1'b0, 16'd9,  24'd10, 1'b1); // 14
      add( 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'd14, 1'b0, 16'd9,  24'd11, 1'b1);
      add( 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'd14, 1'b0, 16'd9,  24'd11, 1'b1);
      add( 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'd14, 1'b0, 16'd9,  24'd11, 1'b1);
      add( 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'd6,  1'b0, 16'd10, 24'd11, 1'b1); // 6
      add( 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'd6,  1'b0, 16'd10, 24'd10, 1'b1);
      add( 2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'd6,  1'b0, 16'd10, 24'd10, 1'b1);
      add( 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'd6,  1'b0, 16'd10, 24'd10, 1'b1);
      add( 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'd8,  1'b0, 16'd11, 24'd10, 1'b1); // 8
      add( 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'd8,  1'b0, 16'd11, 24'd9,  1'b1);
      add( 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24'd8,  1'b0, 16'd11, 24'd9,  1'b1); // cnt=7

      // Reset state
      rst = 1'b0; en = 1'b0; peak = 1'b0; rr_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_blank", 64'(blank), 64'd0);
      chk("reset_valid", 64'(rr_valid), 64'd0);
      chk("reset_count", 64'(rr_count), 64'd0);
      chk("reset_timeout", 64'(timeout), 64'd0);
      chk("reset_beat", 64'(beat_count), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // Table-driven run through the scoreboard
      foreach (segs[s]) begin
         for (int k = 0; k < segs[s].n; k++) begin
            @(negedge clk);
            en = segs[s].en; peak = segs[s].peak; rr_ready = segs[s].rdy;
            sb_q.push_back(segs[s]);
            @(posedge clk);
            #1;
            ex = sb_q.pop_front();
            chk("blank", 64'(blank), 64'(ex.blank));
            chk("rr_valid", 64'(rr_valid), 64'(ex.valid));
            chk("rr_count", 64'(rr_count), 64'(ex.cnt));
            chk("timeout", 64'(timeout), 64'(ex.to));
            chk("beat_count", 64'(beat_count), 64'(ex.beat));
`ifdef RR_AVG_EN
            chk("rr_avg", 64'(rr_avg), 64'(ex.avg));
            chk("rr_overrun", 64'(rr_overrun), 64'(ex.ovr));
`endif
            row++;
         end
      end

      // Asynchronous reset mid-SEARCH with rr_valid=1 and counter=7
      #2;
      peak = 1'b0;
      rst  = 1'b0;
      #1;
      chk("async_blank", 64'(blank), 64'd0);
      chk("async_valid", 64'(rr_valid), 64'd0);
      chk("async_count", 64'(rr_count), 64'd0);
      chk("async_timeout", 64'(timeout), 64'd0);
      chk("async_beat", 64'(beat_count), 64'd0);
`ifdef RR_AVG_EN
      chk("async_avg", 64'(rr_avg), 64'd0);
      chk("async_overrun", 64'(rr_overrun), 64'd0);
`endif

      // Restart: IDLE -> ARM, and the first peak emits no interval
      @(negedge clk);
      rst = 1'b1; en = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_blank", 64'(blank), 64'd0);
      @(negedge clk);
      en = 1'b1;
      @(posedge clk);
      #1;
      chk("arm_valid", 64'(rr_valid), 64'd0);
      @(negedge clk);
      peak = 1'b1;
      @(posedge clk);
      #1;
      chk("restart_valid", 64'(rr_valid), 64'd0);
      chk("restart_beat", 64'(beat_count), 64'd1);
      chk("restart_blank", 64'(blank), 64'd1);
      @(negedge clk);
      peak = 1'b0;
      @(posedge clk);
      #1;
      chk("restart_valid2", 64'(rr_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
